// File: rtl/arb_pkg.sv
// Shared types and default widths for the fetch/data memory-port arbiter.
package arb_pkg;

    localparam int unsigned DefAddrWidth   = 32;
    localparam int unsigned DefDataWidth   = 32;
    localparam int unsigned DefStarveLimit = 4;

    // Arbiter control state: idle, or owning the memory port for one requester
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DATA  = 2'd2
    } arbState_t;

    // Which requester wins the current arbitration
    typedef enum logic {
        GNT_FETCH = 1'b0,
        GNT_DATA  = 1'b1
    } grantSel_t;

endpackage

// File: rtl/arb_starve_cnt.sv
// Saturating count of consecutive data grants taken while a fetch is waiting.
module arb_starve_cnt
    import arb_pkg::*;
#(
    parameter  int unsigned LIMIT = DefStarveLimit,
    localparam int unsigned CntW  = $clog2(LIMIT + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            incEn,
    input  logic            clrEn,
    output logic [CntW-1:0] count
);

    // Clear wins over increment; hold once the limit is reached
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clrEn) begin
            count <= '0;
        end else if (incEn && (count != CntW'(LIMIT))) begin
            count <= count + CntW'(1);
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data load/store.
// Data has priority. Build macro ARB_STARVE_GUARD_EN adds a starvation guard
// that hands the port to a waiting fetch after STARVE_LIMIT data grants.
// A requester holds its request until its valid pulse and must drop or change
// it in that same cycle, otherwise the held request is arbitrated again.
module mem_port_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned AW           = DefAddrWidth,
    parameter int unsigned DW           = DefDataWidth,
    parameter int unsigned STARVE_LIMIT = DefStarveLimit
) (
    input  logic          clk,
    input  logic          reset,
    // Instruction fetch side
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic [DW-1:0] i_rdata,
    output logic          i_valid,
    // Data side
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_valid,
    // Pipeline stalls
    output logic          stallF,
    output logic          stallM,
    // Shared memory port
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready
);

    arbState_t     state, stateNext;
    grantSel_t     grantSel;
    logic          starveFire;
    logic          memReqNext, memWeNext;
    logic [AW-1:0] memAddrNext;
    logic [DW-1:0] memWdataNext, iRdataNext, dRdataNext;
    logic          iValidNext, dValidNext;

    // Stalls hold each pipeline stage until its own completion pulse
    assign stallF = i_req & ~i_valid;
    assign stallM = d_req & ~d_valid;

`ifdef ARB_STARVE_GUARD_EN
    localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);

    logic [CntW-1:0] starveCount;
    logic            starveInc, starveClr;

    // Count data grants that make a pending fetch wait; any fetch grant resets
    assign starveInc = (state == IDLE) && d_req && i_req && (grantSel == GNT_DATA);
    assign starveClr = (state == IDLE) && i_req && (grantSel == GNT_FETCH);

    arb_starve_cnt #(
        .LIMIT (STARVE_LIMIT)
    ) u_starveCnt (
        .clk   (clk),
        .reset (reset),
        .incEn (starveInc),
        .clrEn (starveClr),
        .count (starveCount)
    );

    // Guard overrides data priority once the waiting fetch has hit the limit
    assign starveFire = i_req && (starveCount == CntW'(STARVE_LIMIT));
`else
    // Strict data priority
    assign starveFire = 1'b0;
`endif

    // Arbitration: fetch only when data is idle or the guard fires
    assign grantSel = (i_req && (!d_req || starveFire)) ? GNT_FETCH : GNT_DATA;

    // Next state and next registered port/response values
    always_comb begin
        stateNext    = state;
        memReqNext   = mem_req;
        memWeNext    = mem_we;
        memAddrNext  = mem_addr;
        memWdataNext = mem_wdata;
        iRdataNext   = i_rdata;
        dRdataNext   = d_rdata;
        iValidNext   = 1'b0;
        dValidNext   = 1'b0;

        unique case (state)
            IDLE: begin
                memReqNext = 1'b0;
                if (i_req || d_req) begin
                    memReqNext = 1'b1;
                    if (grantSel == GNT_FETCH) begin
                        stateNext    = FETCH;
                        memWeNext    = 1'b0;
                        memAddrNext  = i_addr;
                        memWdataNext = '0;
                    end else begin
                        stateNext    = DATA;
                        memWeNext    = d_we;
                        memAddrNext  = d_addr;
                        memWdataNext = d_wdata;
                    end
                end
            end
            FETCH: begin
                if (mem_ready) begin
                    stateNext  = IDLE;
                    memReqNext = 1'b0;
                    memWeNext  = 1'b0;
                    iRdataNext = mem_rdata;
                    iValidNext = 1'b1;
                end
            end
            DATA: begin
                if (mem_ready) begin
                    stateNext  = IDLE;
                    memReqNext = 1'b0;
                    memWeNext  = 1'b0;
                    dRdataNext = mem_rdata;
                    dValidNext = 1'b1;
                end
            end
            default: begin
                stateNext  = IDLE;
                memReqNext = 1'b0;
                memWeNext  = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset abandons any in-flight access
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            i_rdata   <= '0;
            d_rdata   <= '0;
            i_valid   <= 1'b0;
            d_valid   <= 1'b0;
        end else begin
            state     <= stateNext;
            mem_req   <= memReqNext;
            mem_we    <= memWeNext;
            mem_addr  <= memAddrNext;
            mem_wdata <= memWdataNext;
            i_rdata   <= iRdataNext;
            d_rdata   <= dRdataNext;
            i_valid   <= iValidNext;
            d_valid   <= dValidNext;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a wait-state memory model.
// Expectations follow the build macro ARB_STARVE_GUARD_EN.
module tb_mem_port_arbiter;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } memOp_t;

    typedef struct packed {
        logic        isWrite;
        logic [31:0] data;
    } dResp_t;

    logic        clk, reset;
    logic        i_req, i_valid, d_req, d_we, d_valid, stallF, stallM;
    logic [31:0] i_addr, i_rdata, d_addr, d_wdata, d_rdata;
    logic        mem_req, mem_we, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int          nVec = 0;
    int          nMis = 0;
    logic [31:0] expI[$];
    dResp_t      expD[$];
    memOp_t      expMem[$];
    logic [31:0] memArr[logic [31:0]];
    int          waitCfg  = 0;
    logic        spurious = 1'b0;

    mem_port_arbiter #(.AW(32), .DW(32), .STARVE_LIMIT(4)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_valid(i_valid),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_valid(d_valid),
        .stallF(stallF), .stallM(stallM),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] memRead(input logic [31:0] a);
        if (memArr.exists(a)) return memArr[a];
        return 32'h0;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nVec++;
        if (act !== exp) begin
            nMis++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic failNow(input string name);
        nVec++;
        nMis++;
        $display("FAIL %s: got timeout, required completion", name);
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Memory model: ready after waitCfg wait cycles, reads/writes memArr
    initial begin : memModel
        logic seen;
        int   left;
        seen = 1'b0;
        left = 0;
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (!mem_req) begin
                seen      = 1'b0;
                mem_ready = spurious;
                mem_rdata = 32'hBAD0BAD0;
            end else begin
                if (!seen) begin
                    seen = 1'b1;
                    left = waitCfg;
                end
                if (left == 0) begin
                    mem_ready = 1'b1;
                    mem_rdata = memRead(mem_addr);
                    if (mem_we) memArr[mem_addr] = mem_wdata;
                end else begin
                    mem_ready = 1'b0;
                    left--;
                end
            end
        end
    end

    // Memory-side scoreboard: order and fields of each accepted access
    always @(posedge clk) begin
        if (!reset && mem_req && mem_ready) begin
            memOp_t e;
            nVec++;
            if (expMem.size() == 0) begin
                nMis++;
                $display("FAIL mem_op_unexpected: got addr %h, required none", mem_addr);
            end else begin
                e = expMem.pop_front();
                if (mem_we !== e.we || mem_addr !== e.addr || (e.we && mem_wdata !== e.wdata)) begin
                    nMis++;
                    $display("FAIL mem_op: got we=%b addr=%h wdata=%h, required we=%b addr=%h wdata=%h",
                             mem_we, mem_addr, mem_wdata, e.we, e.addr, e.wdata);
                end
            end
        end
    end

    // Response scoreboard: every valid pulse must match a queued expectation
    always @(negedge clk) begin
        logic [31:0] eI;
        dResp_t      eD;
        if (i_valid) begin
            nVec++;
            if (expI.size() == 0) begin
                nMis++;
                $display("FAIL i_valid_unexpected: got pulse, required none");
            end else begin
                eI = expI.pop_front();
                if (i_rdata !== eI) begin
                    nMis++;
                    $display("FAIL i_rdata: got %h, required %h", i_rdata, eI);
                end
            end
        end
        if (d_valid) begin
            nVec++;
            if (expD.size() == 0) begin
                nMis++;
                $display("FAIL d_valid_unexpected: got pulse, required none");
            end else begin
                eD = expD.pop_front();
                if (!eD.isWrite && d_rdata !== eD.data) begin
                    nMis++;
                    $display("FAIL d_rdata: got %h, required %h", d_rdata, eD.data);
                end
            end
        end
    end

    // Single-requester transaction: returns latency, stall cycles, cycles address held
    task automatic runOne(input logic isFetch, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] expData,
                          output int lat, output int stallCyc, output int addrHeld);
        lat      = -1;
        stallCyc = 0;
        addrHeld = 0;
        expMem.push_back('{we: we, addr: addr, wdata: wdata});
        if (isFetch) begin
            expI.push_back(expData);
            i_addr = addr;
            i_req  = 1'b1;
        end else begin
            expD.push_back('{isWrite: we, data: expData});
            d_addr  = addr;
            d_we    = we;
            d_wdata = wdata;
            d_req   = 1'b1;
        end
        #1;
        for (int c = 0; c < 50 && lat < 0; c++) begin
            if (isFetch ? i_valid : d_valid) begin
                lat = c;
            end else begin
                if (isFetch ? stallF : stallM) stallCyc++;
                if (mem_req && mem_addr == addr) addrHeld++;
                tick();
            end
        end
        i_req = 1'b0;
        d_req = 1'b0;
        if (lat < 0) failNow("transaction_timeout");
    endtask

    int          lat, stc, ah, dAt, iAt, nGrant, pulses;
    logic        stallOk, prevReq, done;
    logic [4:0]  expSeq;

    initial begin
        reset = 1'b1;
        i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        memArr[32'd0]   = 32'h00500113;
        memArr[32'd4]   = 32'h00000013;
        memArr[32'd8]   = 32'h00000093;
        memArr[32'd96]  = 32'h12345678;
        memArr[32'd200] = 32'hD00D00C8;
        tick(); tick();

        // Reset state
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_i_valid", i_valid, 0);
        check("rst_d_valid", d_valid, 0);
        check("rst_i_rdata", i_rdata, 0);
        check("rst_d_rdata", d_rdata, 0);
        reset = 1'b0;
        tick();

        // Fetch only, one-cycle memory
        runOne(1'b1, 1'b0, 32'd0, 32'd0, 32'h00500113, lat, stc, ah);
        check("fetch_latency", lat, 2);
        check("fetch_stallF_cycles", stc, 2);
        tick();
        check("fetch_valid_one_cycle", i_valid, 0);
        check("idle_mem_req", mem_req, 0);
        tick(); tick();
        check("i_rdata_hold", i_rdata, 32'h00500113);

        // Collision: write wins, fetch follows; stallF held until fetch completes
        expMem.push_back('{we: 1'b1, addr: 32'd100, wdata: 32'd25});
        expMem.push_back('{we: 1'b0, addr: 32'd4, wdata: 32'd0});
        expD.push_back('{isWrite: 1'b1, data: 32'd0});
        expI.push_back(32'h00000013);
        d_addr = 32'd100; d_we = 1'b1; d_wdata = 32'd25; d_req = 1'b1;
        i_addr = 32'd4; i_req = 1'b1;
        #1;
        dAt = -1; iAt = -1; stallOk = 1'b1;
        for (int c = 0; c < 40 && iAt < 0; c++) begin
            if (d_valid) begin
                dAt   = c;
                d_req = 1'b0;
            end
            if (i_valid) begin
                iAt   = c;
                i_req = 1'b0;
            end else if (!stallF) begin
                stallOk = 1'b0;
            end
            if (iAt < 0) tick();
        end
        check("collision_d_valid_cycle", dAt, 2);
        check("collision_i_valid_cycle", iAt, 4);
        check("collision_stallF_held", stallOk, 1);
        tick();

        // Read back the written word
        runOne(1'b0, 1'b0, 32'd100, 32'd0, 32'd25, lat, stc, ah);
        check("readback_latency", lat, 2);
        check("readback_stallM_cycles", stc, 2);
        tick();

        // mem_ready while idle is ignored
        spurious = 1'b1;
        pulses = 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (i_valid || d_valid || mem_req) pulses++;
        end
        spurious = 1'b0;
        check("idle_ready_ignored", pulses, 0);
        tick();

        // Wait states: three cycles of mem_ready low on a read of 96
        waitCfg = 3;
        runOne(1'b0, 1'b0, 32'd96, 32'd0, 32'h12345678, lat, stc, ah);
        check("wait_latency", lat, 5);
        check("wait_addr_stable_cycles", ah, 4);
        pulses = 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (d_valid) pulses++;
        end
        check("wait_single_d_valid", pulses, 0);
        check("d_rdata_hold", d_rdata, 32'h12345678);
        waitCfg = 0;

        // Starvation: data held continuously while a fetch waits
`ifdef ARB_STARVE_GUARD_EN
        expSeq = 5'b10000;
`else
        expSeq = 5'b00000;
`endif
        for (int k = 0; k < 5; k++) begin
            if (expSeq[k]) begin
                expI.push_back(32'h00000093);
                expMem.push_back('{we: 1'b0, addr: 32'd8, wdata: 32'd0});
            end else begin
                expD.push_back('{isWrite: 1'b0, data: 32'hD00D00C8});
                expMem.push_back('{we: 1'b0, addr: 32'd200, wdata: 32'd0});
            end
        end
        i_addr = 32'd8; i_req = 1'b1;
        d_addr = 32'd200; d_we = 1'b0; d_wdata = 32'd0; d_req = 1'b1;
        #1;
        nGrant = 0; prevReq = 1'b0; done = 1'b0;
        for (int c = 0; c < 80 && !done; c++) begin
            if (mem_req && !prevReq) begin
                if (nGrant < 5)
                    check($sformatf("starve_grant%0d_is_fetch", nGrant), (mem_addr == 32'd8), expSeq[nGrant]);
                nGrant++;
            end
            prevReq = mem_req;
            if (nGrant >= 5 && (i_valid || d_valid)) begin
                i_req = 1'b0;
                d_req = 1'b0;
                done  = 1'b1;
            end else begin
                tick();
            end
        end
        if (!done) failNow("starve_sequence");
        i_req = 1'b0; d_req = 1'b0;
        tick(); tick();

        // Reset during a data access with the memory still busy
        waitCfg = 5;
        d_addr = 32'd96; d_we = 1'b0; d_req = 1'b1;
        tick(); tick();
        check("pre_reset_mem_req", mem_req, 1);
        reset = 1'b1;
        #1;
        check("reset_mem_req_drop", mem_req, 0);
        check("reset_mem_addr", mem_addr, 0);
        d_req = 1'b0;
        pulses = 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (d_valid) pulses++;
        end
        check("reset_no_d_valid", pulses, 0);
        check("reset_d_rdata", d_rdata, 0);
        check("reset_i_rdata", i_rdata, 0);
        reset = 1'b0;
        waitCfg = 0;
        tick();
        runOne(1'b1, 1'b0, 32'd0, 32'd0, 32'h00500113, lat, stc, ah);
        check("post_reset_fetch_latency", lat, 2);
        tick(); tick();

        check("expI_drained", expI.size(), 0);
        check("expD_drained", expD.size(), 0);
        check("expMem_drained", expMem.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule
